// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - fetch/decode stage with stall, branch redirect, RAW bubble and halt
module fetch_decode_stage #(
  parameter int                PC_W      = 6,
  parameter int                INSTR_W   = 16,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter logic [4:0]        HALT_OPC  = 5'b11111,
  parameter bit                HAZARD_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [4:0]         opcode,
  output logic               am,
  output logic [2:0]         rd,
  output logic [2:0]         rs1,
  output logic [2:0]         rs2,
  output logic [2:0]         s_r_amount,
  output logic [3:0]         mem_addr,
  output logic [5:0]         instr_mem_addr,
  output logic               enable,
  output logic [PC_W-1:0]    pc_out,
  output logic               halted
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HAZARD = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   pc_out_q, pc_out_d;
  logic [4:0]        opcode_q, opcode_d;
  logic              am_q, am_d;
  logic [2:0]        rd_q, rd_d;
  logic [2:0]        rs1_q, rs1_d;
  logic [2:0]        rs2_q, rs2_d;
  logic [2:0]        s_r_amount_q, s_r_amount_d;
  logic [3:0]        mem_addr_q, mem_addr_d;
  logic [5:0]        instr_mem_addr_q, instr_mem_addr_d;
  logic              enable_q, enable_d;
  logic              halted_q, halted_d;

  // Fields of the incoming instruction (only the low 16 bits carry meaning)
  logic [15:0] instr;
  logic [4:0]  in_opcode;
  logic        in_am;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic        issued_writes_rd;
  logic        hazard;

  // Slice the incoming word and detect a read of the register the issued op is writing
  always_comb begin
    instr            = imem_data[15:0];
    in_opcode        = instr[15:11];
    in_am            = instr[10];
    in_rd            = instr[9:7];
    in_rs1           = instr[6:4];
    in_rs2           = instr[3:1];
    issued_writes_rd = (opcode_q[4:3] != 2'b11);
    hazard           = enable_q && issued_writes_rd &&
                       ((in_rs1 == rd_q) || (!in_am && (in_rs2 == rd_q)));
  end

  // Next-state selection: halt > branch > stall > halt opcode > bubble > issue
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pc_out_d         = pc_out_q;
    opcode_d         = opcode_q;
    am_d             = am_q;
    rd_d             = rd_q;
    rs1_d            = rs1_q;
    rs2_d            = rs2_q;
    s_r_amount_d     = s_r_amount_q;
    mem_addr_d       = mem_addr_q;
    instr_mem_addr_d = instr_mem_addr_q;
    enable_d         = enable_q;
    halted_d         = halted_q;

    if (state_q == ST_HALT) begin
      enable_d = 1'b0;
    end else if (branch_taken) begin
      pc_d     = branch_target;
      enable_d = 1'b0;
      state_d  = ST_RUN;
    end else if (stall) begin
      // hold every register
    end else if (in_opcode == HALT_OPC) begin
      enable_d = 1'b0;
      state_d  = ST_HALT;
      halted_d = 1'b1;
    end else if (HAZARD_EN && hazard) begin
      enable_d = 1'b0;
      state_d  = ST_HAZARD;
    end else begin
      opcode_d         = in_opcode;
      am_d             = in_am;
      rd_d             = in_rd;
      rs1_d            = in_rs1;
      rs2_d            = in_rs2;
      s_r_amount_d     = instr[3:1];
      mem_addr_d       = instr[3:0];
      instr_mem_addr_d = instr[5:0];
      pc_out_d         = pc_q;
      enable_d         = 1'b1;
      pc_d             = pc_q + PC_W'(1);
      state_d          = ST_RUN;
    end
  end

  // State, PC and registered outputs; async reset returns everything to reset values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_RUN;
      pc_q             <= RESET_PC;
      pc_out_q         <= '0;
      opcode_q         <= '0;
      am_q             <= 1'b0;
      rd_q             <= '0;
      rs1_q            <= '0;
      rs2_q            <= '0;
      s_r_amount_q     <= '0;
      mem_addr_q       <= '0;
      instr_mem_addr_q <= '0;
      enable_q         <= 1'b0;
      halted_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      pc_out_q         <= pc_out_d;
      opcode_q         <= opcode_d;
      am_q             <= am_d;
      rd_q             <= rd_d;
      rs1_q            <= rs1_d;
      rs2_q            <= rs2_d;
      s_r_amount_q     <= s_r_amount_d;
      mem_addr_q       <= mem_addr_d;
      instr_mem_addr_q <= instr_mem_addr_d;
      enable_q         <= enable_d;
      halted_q         <= halted_d;
    end
  end

  assign imem_addr      = pc_q;
  assign opcode         = opcode_q;
  assign am             = am_q;
  assign rd             = rd_q;
  assign rs1            = rs1_q;
  assign rs2            = rs2_q;
  assign s_r_amount     = s_r_amount_q;
  assign mem_addr       = mem_addr_q;
  assign instr_mem_addr = instr_mem_addr_q;
  assign enable         = enable_q;
  assign pc_out         = pc_out_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb/tb_fetch_decode_stage.sv - scoreboard bench for fetch_decode_stage
module tb_fetch_decode_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [5:0]  branch_target;
  logic [15:0] imem [64];

  logic [5:0]  imem_addr, pc_out, instr_mem_addr;
  logic [15:0] imem_data;
  logic [4:0]  opcode;
  logic        am, enable, halted;
  logic [2:0]  rd, rs1, rs2, s_r_amount;
  logic [3:0]  mem_addr;

  logic [5:0]  nh_imem_addr, nh_pc_out, nh_instr_mem_addr;
  logic [15:0] nh_imem_data;
  logic [4:0]  nh_opcode;
  logic        nh_am, nh_enable, nh_halted;
  logic [2:0]  nh_rd, nh_rs1, nh_rs2, nh_s_r_amount;
  logic [3:0]  nh_mem_addr;

  assign imem_data    = imem[imem_addr];
  assign nh_imem_data = imem[nh_imem_addr];

  fetch_decode_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .opcode(opcode), .am(am), .rd(rd), .rs1(rs1), .rs2(rs2),
    .s_r_amount(s_r_amount), .mem_addr(mem_addr), .instr_mem_addr(instr_mem_addr),
    .enable(enable), .pc_out(pc_out), .halted(halted)
  );

  fetch_decode_stage #(.HAZARD_EN(1'b0)) dut_nh (
    .clk(clk), .reset(reset), .imem_addr(nh_imem_addr), .imem_data(nh_imem_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .opcode(nh_opcode), .am(nh_am), .rd(nh_rd), .rs1(nh_rs1), .rs2(nh_rs2),
    .s_r_amount(nh_s_r_amount), .mem_addr(nh_mem_addr), .instr_mem_addr(nh_instr_mem_addr),
    .enable(nh_enable), .pc_out(nh_pc_out), .halted(nh_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  pc;
    logic [15:0] instr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic stall_at_edge = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [4:0] opc, input logic a, input logic [2:0] d,
                                     input logic [2:0] s1, input logic [2:0] s2, input logic b0);
    return {opc, a, d, s1, s2, b0};
  endfunction

  task automatic push(input logic [5:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = imem[pc];
    sb.push_back(e);
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_stream();
    for (int i = 0; i < 64; i++) imem[i] = 16'h0;
    imem[0] = mk(5'b00001, 1'b1, 3'd1, 3'd2, 3'd3, 1'b0);
    imem[1] = mk(5'b00010, 1'b0, 3'd4, 3'd5, 3'd6, 1'b1);
    imem[2] = mk(5'b00011, 1'b1, 3'd7, 3'd0, 3'd2, 1'b0);
    imem[3] = mk(5'b11111, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
  endtask

  // Remember whether the last rising edge was stalled, so a held issue is not counted twice
  always @(posedge clk) stall_at_edge <= stall;

  // Monitor: every fresh issue is compared against the oldest expected instruction
  always @(negedge clk) begin
    if (reset && enable && !stall_at_edge) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_issue", {26'd0, pc_out}, 32'hFFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_pc_out",         {26'd0, pc_out},         {26'd0, mon_e.pc});
        chk("sb_opcode",         {27'd0, opcode},         {27'd0, mon_e.instr[15:11]});
        chk("sb_am",             {31'd0, am},             {31'd0, mon_e.instr[10]});
        chk("sb_rd",             {29'd0, rd},             {29'd0, mon_e.instr[9:7]});
        chk("sb_rs1",            {29'd0, rs1},            {29'd0, mon_e.instr[6:4]});
        chk("sb_rs2",            {29'd0, rs2},            {29'd0, mon_e.instr[3:1]});
        chk("sb_s_r_amount",     {29'd0, s_r_amount},     {29'd0, mon_e.instr[3:1]});
        chk("sb_mem_addr",       {28'd0, mem_addr},       {28'd0, mon_e.instr[3:0]});
        chk("sb_instr_mem_addr", {26'd0, instr_mem_addr}, {26'd0, mon_e.instr[5:0]});
      end
    end
  end

  initial begin
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 6'd0;
    load_stream();
    nclk(3);
    chk("rst_pc",      {26'd0, imem_addr}, 32'd0);
    chk("rst_enable",  {31'd0, enable},    32'd0);
    chk("rst_halted",  {31'd0, halted},    32'd0);
    chk("rst_pc_out",  {26'd0, pc_out},    32'd0);
    chk("rst_opcode",  {27'd0, opcode},    32'd0);

    // Streaming three independent ops, then halt
    push(6'd0); push(6'd1); push(6'd2);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nclk(1);
      chk("stream_enable", {31'd0, enable}, 32'd1);
    end
    nclk(1);
    chk("halt_halted",  {31'd0, halted},    32'd1);
    chk("halt_enable",  {31'd0, enable},    32'd0);
    chk("halt_pc",      {26'd0, imem_addr}, 32'd3);
    chk("halt_pc_out",  {26'd0, pc_out},    32'd2);
    branch_taken = 1'b1; branch_target = 6'd10;
    nclk(1);
    branch_taken = 1'b0;
    chk("halt_br_pc",     {26'd0, imem_addr}, 32'd3);
    chk("halt_br_halted", {31'd0, halted},    32'd1);
    nclk(3);
    chk("halt_hold_enable", {31'd0, enable}, 32'd0);
    chk("halt_hold_halted", {31'd0, halted}, 32'd1);
    chk("stream_sb_empty", sb.size(), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_pc",     {26'd0, imem_addr}, 32'd0);
    chk("async_rst_enable", {31'd0, enable},    32'd0);
    chk("async_rst_halted", {31'd0, halted},    32'd0);

    // Stall for three edges after the first issue
    nclk(1);
    push(6'd0); push(6'd1); push(6'd2);
    reset = 1'b1;
    nclk(1);
    chk("restart_pc_out", {26'd0, pc_out}, 32'd0);
    chk("restart_enable", {31'd0, enable}, 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nclk(1);
      chk("stall_enable", {31'd0, enable},    32'd1);
      chk("stall_pc_out", {26'd0, pc_out},    32'd0);
      chk("stall_pc",     {26'd0, imem_addr}, 32'd1);
      chk("stall_opcode", {27'd0, opcode},    32'd1);
    end
    stall = 1'b0;
    nclk(1);
    chk("unstall_pc_out", {26'd0, pc_out}, 32'd1);
    nclk(2);
    chk("stall_halted", {31'd0, halted}, 32'd1);
    chk("stall_sb_empty", sb.size(), 32'd0);
    #2 reset = 1'b0;

    // RAW hazard: imem[1] reads r1 written by imem[0]
    nclk(1);
    imem[0] = mk(5'b00110, 1'b1, 3'd1, 3'd2, 3'd3, 1'b0);
    imem[1] = mk(5'b00001, 1'b0, 3'd2, 3'd1, 3'd0, 1'b0);
    imem[2] = mk(5'b00010, 1'b1, 3'd3, 3'd4, 3'd5, 1'b0);
    push(6'd0); push(6'd1); push(6'd2);
    reset = 1'b1;
    nclk(1);
    chk("haz_c1_enable",    {31'd0, enable},    32'd1);
    chk("nh_c1_pc_out",     {26'd0, nh_pc_out}, 32'd0);
    nclk(1);
    chk("haz_bubble_enable", {31'd0, enable},    32'd0);
    chk("haz_bubble_pc",     {26'd0, imem_addr}, 32'd1);
    chk("haz_bubble_opcode", {27'd0, opcode},    32'd6);
    chk("nh_c2_enable",      {31'd0, nh_enable}, 32'd1);
    chk("nh_c2_pc_out",      {26'd0, nh_pc_out}, 32'd1);
    nclk(1);
    chk("haz_c3_enable", {31'd0, enable},    32'd1);
    chk("haz_c3_pc_out", {26'd0, pc_out},    32'd1);
    chk("nh_c3_pc_out",  {26'd0, nh_pc_out}, 32'd2);
    nclk(2);
    chk("haz_halted", {31'd0, halted}, 32'd1);
    chk("haz_sb_empty", sb.size(), 32'd0);
    #2 reset = 1'b0;

    // Branch together with stall, then wrap 63 -> 0
    nclk(1);
    for (int i = 0; i < 64; i++) begin
      logic [5:0] idx;
      idx = 6'(i);
      imem[i] = {5'b00001, 1'b1, 3'b111, 3'b000, idx[3:0]};
    end
    push(6'd0); push(6'd40); push(6'd41); push(6'd63); push(6'd0); push(6'd1);
    reset = 1'b1;
    nclk(1);
    branch_taken = 1'b1; branch_target = 6'd40; stall = 1'b1;
    nclk(1);
    chk("br_stall_pc",     {26'd0, imem_addr}, 32'd40);
    chk("br_stall_enable", {31'd0, enable},    32'd0);
    branch_taken = 1'b0; stall = 1'b0;
    nclk(1);
    chk("br_issue_pc_out", {26'd0, pc_out}, 32'd40);
    chk("br_issue_enable", {31'd0, enable}, 32'd1);
    nclk(1);
    branch_taken = 1'b1; branch_target = 6'd63;
    nclk(1);
    chk("br63_pc",     {26'd0, imem_addr}, 32'd63);
    chk("br63_enable", {31'd0, enable},    32'd0);
    branch_taken = 1'b0;
    nclk(1);
    chk("wrap_pc_out_63", {26'd0, pc_out},    32'd63);
    chk("wrap_pc",        {26'd0, imem_addr}, 32'd0);
    nclk(1);
    chk("wrap_pc_out_0", {26'd0, pc_out}, 32'd0);
    nclk(1);
    #2 reset = 1'b0;
    #1;
    chk("br_sb_empty", sb.size(), 32'd0);

    nclk(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
